capture_memory_ctrl: RTL

Single-clock, parametrised capture memory for the ADC data path, replacing the fixed-size BRAM FIFO and read mux pair. It stores packed ADC words, each holding BRAM_WORD_NUM samples, in a circular buffer. Capture is armed by software, with a programmable pre-trigger depth and an external or immediate trigger. After capture, the buffer is read back one sample per cycle in chronological order, oldest sample first. It sits between the ADC deserialiser/packer and the USB/SPI readout interface.

---
 rtl/capture_memory_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/capture_memory_ctrl.sv
// Circular capture memory for packed ADC words: armed capture with pre-trigger depth,
// then chronological per-sample readout through a two-stage read pipeline.
module capture_memory_ctrl #(
    parameter int ADC_MAX_DATA_SIZE = 16,
    parameter int BRAM_WORD_NUM     = 8,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                                          i_capture_memory_clk,
    input  logic                                          i_capture_memory_reset,
    input  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0]    i_capture_memory_wr_data,
    input  logic                                          i_capture_memory_wr_clk_en,
    input  logic                                          i_capture_memory_arm,
    input  logic                                          i_capture_memory_abort,
    input  logic [ADDR_WIDTH-1:0]                         i_capture_memory_pretrig,
    input  logic                                          i_capture_memory_ext_trig,
    input  logic                                          i_capture_memory_ext_trig_en,
    input  logic                                          i_capture_memory_rd_en,
    output logic [ADC_MAX_DATA_SIZE-1:0]                  o_capture_memory_rd_data,
    output logic                                          o_capture_memory_rd_valid,
    output logic                                          o_capture_memory_rd_last,
    output logic                                          o_capture_memory_busy,
    output logic                                          o_capture_memory_ready,
    output logic [ADDR_WIDTH-1:0]                         o_capture_memory_trig_addr
);

    localparam int DW     = ADC_MAX_DATA_SIZE;
    localparam int WORD_W = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_W = (BRAM_WORD_NUM > 1) ? $clog2(BRAM_WORD_NUM) : 1;
    localparam int CNT_W  = ADDR_WIDTH + $clog2(BRAM_WORD_NUM);

    localparam logic [ADDR_WIDTH-1:0] A_ONE    = 1;
    localparam logic [LANE_W-1:0]     L_ONE    = 1;
    localparam logic [LANE_W-1:0]     LANE_MAX = LANE_W'(BRAM_WORD_NUM - 1);
    localparam logic [CNT_W-1:0]      C_ONE    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_READOUT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_WIDTH-1:0]   pretrig_q, pretrig_d;
    logic                    ext_mode_q, ext_mode_d;
    logic [ADDR_WIDTH-1:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
    logic                    ext_trig_q, ext_trig_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [LANE_W-1:0]       rd_lane_q, rd_lane_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    rd_done_q, rd_done_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [LANE_W-1:0]       s1_lane_q, s1_lane_d;
    logic                    s1_last_q, s1_last_d;
    logic [DW-1:0]           rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;

    logic                    wr_en;
    logic                    start;
    logic                    ext_rise;
    logic [ADDR_WIDTH-1:0]   post_init;
    logic [WORD_W-1:0]       mem_rd_q;
    logic [DW-1:0]           lanes [BRAM_WORD_NUM];
    logic [DW-1:0]           lane_data;

    logic [WORD_W-1:0]       mem [DEPTH];

    assign ext_rise  = i_capture_memory_ext_trig & ~ext_trig_q;
    assign post_init = ~pretrig_q;

    always_comb begin
        for (int i = 0; i < BRAM_WORD_NUM; i++) begin
            lanes[i] = mem_rd_q[i*DW +: DW];
        end
        lane_data = lanes[s1_lane_q];
    end

    // Read handshake: rd_en high in cycle t issues one sample (while samples remain);
    // it appears with rd_valid high in cycle t+2. No backpressure on the output side.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        pretrig_d   = pretrig_q;
        ext_mode_d  = ext_mode_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        ext_trig_d  = i_capture_memory_ext_trig;
        rd_addr_d   = rd_addr_q;
        rd_lane_d   = rd_lane_q;
        rd_cnt_d    = rd_cnt_q;
        rd_done_d   = rd_done_q;
        s1_valid_d  = 1'b0;
        s1_lane_d   = s1_lane_q;
        s1_last_d   = 1'b0;
        rd_valid_d  = s1_valid_q;
        rd_last_d   = s1_valid_q & s1_last_q;
        rd_data_d   = s1_valid_q ? lane_data : rd_data_q;
        wr_en       = 1'b0;
        start       = 1'b0;

        case (state_q)
            ST_IDLE: start = i_capture_memory_arm;
            ST_FILL: begin
                if (i_capture_memory_wr_clk_en) begin
                    wr_en      = 1'b1;
                    fill_cnt_d = fill_cnt_q + A_ONE;
                    if (fill_cnt_q == pretrig_q - A_ONE) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (i_capture_memory_wr_clk_en) begin
                    wr_en = 1'b1;
                    if (!ext_mode_q || ext_rise) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = post_init;
                        state_d     = (post_init != '0) ? ST_POST : ST_READOUT;
                    end
                end
            end
            ST_POST: begin
                if (i_capture_memory_wr_clk_en) begin
                    wr_en      = 1'b1;
                    post_cnt_d = post_cnt_q - A_ONE;
                    if (post_cnt_q == A_ONE) state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (i_capture_memory_arm) begin
                    start = 1'b1;
                end else begin
                    if (i_capture_memory_rd_en && !rd_done_q) begin
                        s1_valid_d = 1'b1;
                        s1_lane_d  = rd_lane_q;
                        s1_last_d  = &rd_cnt_q;
                        rd_cnt_d   = rd_cnt_q + C_ONE;
                        rd_done_d  = &rd_cnt_q;
                        if (rd_lane_q == LANE_MAX) begin
                            rd_lane_d = '0;
                            rd_addr_d = rd_addr_q + A_ONE;
                        end else begin
                            rd_lane_d = rd_lane_q + L_ONE;
                        end
                    end
                    if (rd_valid_q && rd_last_q) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A restart from READOUT drops whatever is still in the read pipeline.
        if (start) begin
            pretrig_d  = i_capture_memory_pretrig;
            ext_mode_d = i_capture_memory_ext_trig_en;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            state_d    = (i_capture_memory_pretrig != '0) ? ST_FILL : ST_ARMED;
            s1_valid_d = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        if (i_capture_memory_abort) begin
            state_d    = ST_IDLE;
            wr_en      = 1'b0;
            s1_valid_d = 1'b0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + A_ONE;

        // Oldest retained word sits P words before the trigger word.
        if (state_d == ST_READOUT && state_q != ST_READOUT) begin
            rd_addr_d = trig_addr_d - pretrig_q;
            rd_lane_d = '0;
            rd_cnt_d  = '0;
            rd_done_d = 1'b0;
        end

        busy_d  = (state_d == ST_FILL) || (state_d == ST_ARMED) || (state_d == ST_POST);
        ready_d = (state_d == ST_READOUT);
    end

    always_ff @(posedge i_capture_memory_clk) begin
        if (i_capture_memory_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            pretrig_q   <= '0;
            ext_mode_q  <= 1'b0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            ext_trig_q  <= 1'b0;
            rd_addr_q   <= '0;
            rd_lane_q   <= '0;
            rd_cnt_q    <= '0;
            rd_done_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_lane_q   <= '0;
            s1_last_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            pretrig_q   <= pretrig_d;
            ext_mode_q  <= ext_mode_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            ext_trig_q  <= ext_trig_d;
            rd_addr_q   <= rd_addr_d;
            rd_lane_q   <= rd_lane_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_done_q   <= rd_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_lane_q   <= s1_lane_d;
            s1_last_q   <= s1_last_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    // RAM contents survive reset and abort.
    always_ff @(posedge i_capture_memory_clk) begin
        if (wr_en) mem[wr_ptr_q] <= i_capture_memory_wr_data;
        mem_rd_q <= mem[rd_addr_q];
    end

    assign o_capture_memory_rd_data   = rd_data_q;
    assign o_capture_memory_rd_valid  = rd_valid_q;
    assign o_capture_memory_rd_last   = rd_last_q;
    assign o_capture_memory_busy      = busy_q;
    assign o_capture_memory_ready     = ready_q;
    assign o_capture_memory_trig_addr = trig_addr_q;

endmodule
